uc_multicycle: RTL and testbench

Multi-cycle control unit for the Franklin MIPS-subset core. It replaces the single-cycle combinational decoder with a registered FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It waits on a memory ready handshake with a parametrised timeout and drives the datapath strobes directly. It sits between the instruction register/ALU flags and the datapath muxes and register-file/memory enables.

---
 rtl/uc_pkg.sv | 65 ++++++
 rtl/uc_multicycle_if.sv | 44 ++++
 rtl/uc_wait_timer.sv | 30 +++
 rtl/uc_multicycle.sv | 188 ++++++++++++++++++
 tb/tb_uc_multicycle.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, states,
// datapath mux selects and the instruction classifier.
package uc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_R2   = 6'b011100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd7
  } state_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP, PC_RS} pc_src_e;
  typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA} reg_dst_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_src_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic r_type;
    logic r2;
    logic addi;
    logic slti;
    logic beq;
    logic bne;
    logic lw;
    logic sw;
    logic j;
    logic jal;
    logic jr;
    logic legal;
  } instr_class_t;

  // jr shares the R opcode, so plain R-type excludes the jr funct
  function automatic instr_class_t classify(input logic [5:0] op, input logic [5:0] fn);
    instr_class_t c;
    c.r_type = (op == OP_R) && (fn != FN_JR);
    c.jr     = (op == OP_R) && (fn == FN_JR);
    c.r2     = (op == OP_R2);
    c.addi   = (op == OP_ADDI);
    c.slti   = (op == OP_SLTI);
    c.beq    = (op == OP_BEQ);
    c.bne    = (op == OP_BNE);
    c.lw     = (op == OP_LW);
    c.sw     = (op == OP_SW);
    c.j      = (op == OP_J);
    c.jal    = (op == OP_JAL);
    c.legal  = c.r_type | c.jr | c.r2 | c.addi | c.slti | c.beq | c.bne |
               c.lw | c.sw | c.j | c.jal;
    return c;
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// Bundle between the control unit and the datapath: IR fields and flags in,
// state, strobes and mux selects out.
interface uc_multicycle_if #(
  parameter int RET_W = 16
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             alu_zero;
  logic [2:0]       state;
  logic             ir_write;
  logic             pc_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       pc_src;
  logic [1:0]       reg_dst;
  logic [1:0]       wb_src;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             branch_flag;
  logic             jump_flag;
  logic             jal_flag;
  logic             jr_flag;
  logic             instr_done;
  logic             bus_error;
  logic [RET_W-1:0] instr_count;

  modport master (
    input  opcode, funct, mem_ready, alu_zero,
    output state, ir_write, pc_write, mem_read, mem_write, reg_write,
           pc_src, reg_dst, wb_src, alu_src, alu_op,
           branch_flag, jump_flag, jal_flag, jr_flag,
           instr_done, bus_error, instr_count
  );

  modport slave (
    output opcode, funct, mem_ready, alu_zero,
    input  state, ir_write, pc_write, mem_read, mem_write, reg_write,
           pc_src, reg_dst, wb_src, alu_src, alu_op,
           branch_flag, jump_flag, jal_flag, jr_flag,
           instr_done, bus_error, instr_count
  );
endinterface

// File: rtl/uc_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait and flags the cycle
// on which the wait would exceed TIMEOUT (TIMEOUT of 0 never expires).
module uc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int TMR_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control FSM for the Franklin MIPS-subset core: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TMR_W   = 4,
  parameter int RET_W   = 16
) (
  input logic              clk,
  input logic              rst,
  uc_multicycle_if.master  bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, fn_q;
  logic [RET_W-1:0] count_q;
  logic             bus_error_q;

  instr_class_t cls_live, cls_q, cls;

  logic     ir_write, pc_write, mem_read, mem_write, reg_write, alu_src, instr_done;
  pc_src_e  pc_src;
  reg_dst_e reg_dst;
  wb_src_e  wb_src;
  alu_op_e  alu_op;

  logic tmr_clear, tmr_enable, tmr_expired, waiting;

  // DECODE sees the freshly written IR; later states use the latched copy
  assign cls_live = classify(bus.opcode, bus.funct);
  assign cls_q    = classify(op_q, fn_q);
  assign cls      = (state_q == ST_DECODE) ? cls_live : cls_q;

  assign waiting    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign tmr_enable = waiting && !bus.mem_ready;
  assign tmr_clear  = !waiting || bus.mem_ready;

  uc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      op_q        <= '0;
      fn_q        <= '0;
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      if (instr_done) begin
        count_q <= count_q + 1'b1;
      end
      if (state_d == ST_ERROR) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    instr_done = 1'b0;
    pc_src     = PC_PLUS4;
    reg_dst    = RD_RT;
    wb_src     = WB_ALU;
    alu_op     = ALU_ADD;

    unique case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_DECODE: begin
        if (!cls.legal) begin
          state_d = ST_ERROR;
        end else if (cls.j || cls.jal) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
          if (cls.jal) begin
            reg_write = 1'b1;
            reg_dst   = RD_RA;
            wb_src    = WB_PC4;
          end
        end else if (cls.jr) begin
          pc_write   = 1'b1;
          pc_src     = PC_RS;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cls.r_type || cls.r2) begin
          alu_op  = ALU_FUNCT;
          state_d = ST_WB;
        end else if (cls.addi || cls.slti) begin
          alu_op  = cls.slti ? ALU_SLT : ALU_ADD;
          alu_src = 1'b1;
          state_d = ST_WB;
        end else if (cls.beq || cls.bne) begin
          alu_op     = ALU_SUB;
          pc_src     = PC_BRANCH;
          pc_write   = (cls.beq && bus.alu_zero) || (cls.bne && !bus.alu_zero);
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          alu_src = 1'b1;
          state_d = ST_MEM;
        end else begin
          state_d = ST_ERROR;
        end
      end

      ST_MEM: begin
        mem_read  = cls.lw;
        mem_write = cls.sw;
        if (bus.mem_ready) begin
          instr_done = cls.sw;
          state_d    = cls.sw ? ST_FETCH : ST_WB;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls.r_type || cls.r2) ? RD_RD : RD_RT;
        wb_src     = cls.lw ? WB_MEM : WB_ALU;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_ERROR: state_d = ST_ERROR;

      default: state_d = ST_ERROR;
    endcase
  end

  // Everything the datapath acts on is held low for as long as reset is asserted
  assign bus.state       = state_q;
  assign bus.ir_write    = ir_write & ~rst;
  assign bus.pc_write    = pc_write & ~rst;
  assign bus.mem_read    = mem_read & ~rst;
  assign bus.mem_write   = mem_write & ~rst;
  assign bus.reg_write   = reg_write & ~rst;
  assign bus.alu_src     = alu_src & ~rst;
  assign bus.instr_done  = instr_done & ~rst;
  assign bus.pc_src      = rst ? 2'b00 : pc_src;
  assign bus.reg_dst     = rst ? 2'b00 : reg_dst;
  assign bus.wb_src      = rst ? 2'b00 : wb_src;
  assign bus.alu_op      = rst ? 2'b00 : alu_op;
  assign bus.branch_flag = ~rst & (cls.beq | cls.bne);
  assign bus.jump_flag   = ~rst & (cls.j | cls.jal);
  assign bus.jal_flag    = ~rst & cls.jal;
  assign bus.jr_flag     = ~rst & cls.jr;
  assign bus.bus_error   = bus_error_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Scoreboard bench for uc_multicycle: each instruction is expanded into
// per-cycle expected outputs which are popped and compared as cycles run.
module tb_uc_multicycle;

  localparam int         TIMEOUT = 15;
  localparam logic [5:0] JUNK    = 6'b111111;

  logic clk;
  logic rst;

  uc_multicycle_if #(.RET_W(16)) bus ();

  uc_multicycle #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (4),
    .RET_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       zero;
  } stim_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_w;
    logic        pc_w;
    logic        m_rd;
    logic        m_wr;
    logic        r_wr;
    logic [1:0]  pc_s;
    logic [1:0]  r_d;
    logic [1:0]  wb_s;
    logic        a_s;
    logic [1:0]  a_op;
    logic        done;
    logic        berr;
    logic        chk;
    logic [3:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [15:0] exp_count;
  int          n_checks;
  int          n_pass;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic pushCycle(input logic [5:0] op, input logic [5:0] fn,
                           input logic rdy, input logic zero, input exp_t e);
    stim_t s;
    s.op   = op;
    s.fn   = fn;
    s.rdy  = rdy;
    s.zero = zero;
    e.cnt  = exp_count;
    stim_q.push_back(s);
    exp_q.push_back(e);
    if (e.done) exp_count++;
  endtask

  task automatic pushError(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e      = '0;
      e.st   = 3'd7;
      e.berr = 1'b1;
      pushCycle(JUNK, JUNK, 1'b1, 1'b0, e);
    end
  endtask

  function automatic logic [16:0] strobes();
    return {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
            bus.pc_src, bus.reg_dst, bus.wb_src, bus.alu_src, bus.alu_op,
            bus.instr_done, bus.bus_error};
  endfunction

  // Entered and left at a falling edge; one record per clock cycle
  task automatic runQueue();
    stim_t s;
    exp_t  e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.opcode    = s.op;
      bus.funct     = s.fn;
      bus.mem_ready = s.rdy;
      bus.alu_zero  = s.zero;
      #1;
      checkOutput("state", 32'(bus.state), 32'(e.st));
      checkOutput("strobes", 32'(strobes()),
                  32'({e.ir_w, e.pc_w, e.m_rd, e.m_wr, e.r_wr, e.pc_s, e.r_d, e.wb_s,
                       e.a_s, e.a_op, e.done, e.berr}));
      if (e.chk)
        checkOutput("flags", 32'({bus.branch_flag, bus.jump_flag, bus.jal_flag, bus.jr_flag}),
                    32'(e.flags));
      checkOutput("instr_count", 32'(bus.instr_count), 32'(e.cnt));
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000010;
    bus.funct     = 6'b001000;
    #1;
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_strobes", 32'(strobes()), 32'd0);
    checkOutput("rst_flags", 32'({bus.branch_flag, bus.jump_flag, bus.jal_flag, bus.jr_flag}), 32'd0);
    checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    exp_count = '0;
  endtask

  // Expands one instruction into expected cycles, then runs them
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input int fwait, input int mwait);
    exp_t e;
    logic [3:0] fl;
    logic rr, rr2, addi, slti, beq, bne, lw, sw, jj, jal, jr, legal;
    rr    = (op == 6'b000000) && (fn != 6'b001000);
    jr    = (op == 6'b000000) && (fn == 6'b001000);
    rr2   = (op == 6'b011100);
    addi  = (op == 6'b001000);
    slti  = (op == 6'b001010);
    beq   = (op == 6'b000100);
    bne   = (op == 6'b000101);
    lw    = (op == 6'b100011);
    sw    = (op == 6'b101011);
    jj    = (op == 6'b000010);
    jal   = (op == 6'b000011);
    legal = rr | jr | rr2 | addi | slti | beq | bne | lw | sw | jj | jal;
    fl    = {beq | bne, jj | jal, jal, jr};

    for (int i = 0; i < fwait && i < TIMEOUT; i++) begin
      e = '0; e.m_rd = 1'b1;
      pushCycle(op, fn, 1'b0, zero, e);
    end
    if (fwait >= TIMEOUT) begin
      pushError(3);
      runQueue();
      return;
    end
    e = '0; e.m_rd = 1'b1; e.ir_w = 1'b1; e.pc_w = 1'b1;
    pushCycle(op, fn, 1'b1, zero, e);

    e = '0; e.st = 3'd1; e.chk = 1'b1; e.flags = fl;
    if (jj || jal) begin
      e.pc_w = 1'b1; e.pc_s = 2'd2; e.done = 1'b1;
      if (jal) begin e.r_wr = 1'b1; e.r_d = 2'd2; e.wb_s = 2'd2; end
    end else if (jr) begin
      e.pc_w = 1'b1; e.pc_s = 2'd3; e.done = 1'b1;
    end
    pushCycle(op, fn, 1'b0, zero, e);
    if (!legal) begin
      pushError(3);
      runQueue();
      return;
    end
    if (jj || jal || jr) begin
      runQueue();
      return;
    end

    e = '0; e.st = 3'd2; e.chk = 1'b1; e.flags = fl;
    if (rr || rr2) e.a_op = 2'd2;
    else if (addi) e.a_s = 1'b1;
    else if (slti) begin e.a_op = 2'd3; e.a_s = 1'b1; end
    else if (beq || bne) begin
      e.a_op = 2'd1; e.pc_s = 2'd1; e.done = 1'b1;
      e.pc_w = (beq && zero) || (bne && !zero);
    end else e.a_s = 1'b1;
    pushCycle(JUNK, JUNK, 1'b0, zero, e);
    if (beq || bne) begin
      runQueue();
      return;
    end

    if (lw || sw) begin
      for (int i = 0; i < mwait && i < TIMEOUT; i++) begin
        e = '0; e.st = 3'd3; e.chk = 1'b1; e.flags = fl; e.m_rd = lw; e.m_wr = sw;
        pushCycle(JUNK, JUNK, 1'b0, zero, e);
      end
      if (mwait >= TIMEOUT) begin
        pushError(3);
        runQueue();
        return;
      end
      e = '0; e.st = 3'd3; e.chk = 1'b1; e.flags = fl; e.m_rd = lw; e.m_wr = sw; e.done = sw;
      pushCycle(JUNK, JUNK, 1'b1, zero, e);
      if (sw) begin
        runQueue();
        return;
      end
    end

    e = '0; e.st = 3'd4; e.chk = 1'b1; e.flags = fl; e.r_wr = 1'b1; e.done = 1'b1;
    e.r_d  = (rr || rr2) ? 2'd1 : 2'd0;
    e.wb_s = lw ? 2'd1 : 2'd0;
    pushCycle(JUNK, JUNK, 1'b0, zero, e);
    runQueue();
  endtask

  initial begin
    exp_t e;
    n_checks      = 0;
    n_pass        = 0;
    exp_count     = '0;
    rst           = 1'b1;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    @(negedge clk);
    doReset();

    applyStimulus(6'b001000, 6'b000000, 1'b0, 0, 0);  // addi
    applyStimulus(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
    applyStimulus(6'b000101, 6'b000000, 1'b1, 0, 0);  // bne not taken
    applyStimulus(6'b000100, 6'b000000, 1'b0, 0, 0);  // beq not taken
    applyStimulus(6'b000101, 6'b000000, 1'b0, 0, 0);  // bne taken
    applyStimulus(6'b000011, 6'b000000, 1'b0, 0, 0);  // jal
    applyStimulus(6'b000010, 6'b000000, 1'b0, 0, 0);  // j
    applyStimulus(6'b000000, 6'b001000, 1'b0, 0, 0);  // jr
    applyStimulus(6'b000000, 6'b100000, 1'b0, 0, 0);  // R add
    applyStimulus(6'b011100, 6'b000010, 1'b0, 0, 0);  // R2
    applyStimulus(6'b001010, 6'b000000, 1'b0, 2, 0);  // slti, fetch waits
    applyStimulus(6'b100011, 6'b000000, 1'b0, 0, 3);  // lw, 3 mem waits
    applyStimulus(6'b101011, 6'b000000, 1'b0, 1, 2);  // sw
    applyStimulus(6'b100011, 6'b000000, 1'b0, TIMEOUT - 1, TIMEOUT - 1);  // ready on last allowed cycle

    applyStimulus(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal opcode
    doReset();
    applyStimulus(6'b001000, 6'b000000, 1'b0, TIMEOUT, 0);  // fetch timeout
    doReset();
    applyStimulus(6'b101011, 6'b000000, 1'b0, 0, TIMEOUT);  // mem timeout
    doReset();

    // Abort an lw while it is stalled in MEM
    applyStimulus(6'b001000, 6'b000000, 1'b0, 0, 0);
    e = '0; e.m_rd = 1'b1; e.ir_w = 1'b1; e.pc_w = 1'b1;
    pushCycle(6'b100011, 6'b000000, 1'b1, 1'b0, e);
    e = '0; e.st = 3'd1; e.chk = 1'b1;
    pushCycle(6'b100011, 6'b000000, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd2; e.chk = 1'b1; e.a_s = 1'b1;
    pushCycle(JUNK, JUNK, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd3; e.chk = 1'b1; e.m_rd = 1'b1;
    pushCycle(JUNK, JUNK, 1'b0, 1'b0, e);
    pushCycle(JUNK, JUNK, 1'b0, 1'b0, e);
    runQueue();
    bus.mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_state", 32'(bus.state), 32'd0);
    checkOutput("abort_strobes", 32'(strobes()), 32'd0);
    checkOutput("abort_count", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    exp_count = '0;
    applyStimulus(6'b100011, 6'b000000, 1'b0, 0, 0);  // clean lw after abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
